// File: rtl/l4_trigger_scheduler.sv
// l4_trigger_scheduler
// Delays each of the NUM_L4 L4 trigger sources by its programmed delay, then
// grants pending sources round-robin onto a single valid/ack trigger output
// carrying the source index and that source's latched pretrigger depth.
// Optional feature macro: L4_SCHED_DROP_COUNT_EN adds per-source saturating
// 16-bit drop counters (drop_count_o) with a synchronous clear input.
module l4_trigger_scheduler #(
  parameter int NUM_L4      = 5,
  parameter int PRETRG_BITS = 4,
  parameter int DELAY_BITS  = 8,
  parameter int SRC_BITS    = 3
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NUM_L4-1:0]             l4_i,
  input  logic [PRETRG_BITS*NUM_L4-1:0] pretrigger_vector_i,
  input  logic [DELAY_BITS*NUM_L4-1:0]  delay_vector_i,
  output logic                          trig_o,
  output logic [SRC_BITS-1:0]           trig_src_o,
  output logic [PRETRG_BITS-1:0]        trig_pretrigger_o,
  input  logic                          trig_ack_i,
  output logic [NUM_L4-1:0]             pending_o,
  output logic [NUM_L4-1:0]             drop_o
`ifdef L4_SCHED_DROP_COUNT_EN
  ,
  input  logic                          drop_count_clr_i,
  output logic [NUM_L4*16-1:0]          drop_count_o
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DELAY   = 2'd1,
    ST_PENDING = 2'd2
  } src_state_t;

  // Round-robin arithmetic is done one bit wider so last_grant + i never overflows.
  localparam logic [SRC_BITS:0]   NUM_L4_W  = (SRC_BITS+1)'(NUM_L4);
  localparam logic [SRC_BITS-1:0] LAST_INIT = SRC_BITS'(NUM_L4 - 1);

  logic                   trig_reg;
  logic [SRC_BITS-1:0]    trig_src_reg;
  logic [PRETRG_BITS-1:0] trig_pretrg_reg;
  logic [SRC_BITS-1:0]    last_grant_reg;

  logic                   slot_free;
  logic                   grant_valid;
  logic [SRC_BITS-1:0]    grant_idx;

  logic [NUM_L4-1:0]      pending;
  logic [PRETRG_BITS-1:0] pretrg_lat [NUM_L4];

  assign slot_free         = !trig_reg || trig_ack_i;
  assign trig_o            = trig_reg;
  assign trig_src_o        = trig_src_reg;
  assign trig_pretrigger_o = trig_pretrg_reg;
  assign pending_o         = pending;

  // Round-robin search starting one past the last granted source, with wrap.
  always_comb begin
    logic [SRC_BITS:0] cand;
    logic              found;
    found     = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int i = 1; i <= NUM_L4; i++) begin
      cand = {1'b0, last_grant_reg} + (SRC_BITS+1)'(i);
      if (cand >= NUM_L4_W) begin
        cand = cand - NUM_L4_W;
      end
      if (!found && pending[cand[SRC_BITS-1:0]]) begin
        found     = 1'b1;
        grant_idx = cand[SRC_BITS-1:0];
      end
    end
    grant_valid = found && slot_free;
  end

  // Output slot: load a new grant whenever the slot frees, hold while stalled.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      trig_reg        <= 1'b0;
      trig_src_reg    <= '0;
      trig_pretrg_reg <= '0;
      last_grant_reg  <= LAST_INIT;
    end else if (slot_free) begin
      if (grant_valid) begin
        trig_reg        <= 1'b1;
        trig_src_reg    <= grant_idx;
        trig_pretrg_reg <= pretrg_lat[grant_idx];
        last_grant_reg  <= grant_idx;
      end else begin
        trig_reg <= 1'b0;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_L4; gi++) begin : g_src
      src_state_t             state_reg,  state_next;
      logic [DELAY_BITS-1:0]  count_reg,  count_next;
      logic [PRETRG_BITS-1:0] pretrg_reg, pretrg_next;
      logic                   drop_reg,   drop_next;
      logic                   grant_hit;

      assign grant_hit      = grant_valid && (grant_idx == SRC_BITS'(gi));
      assign pending[gi]    = (state_reg == ST_PENDING);
      assign pretrg_lat[gi] = pretrg_reg;
      assign drop_o[gi]     = drop_reg;

      // Per-source sequencing: capture on pulse, count down, wait for grant.
      always_comb begin
        state_next  = state_reg;
        count_next  = count_reg;
        pretrg_next = pretrg_reg;
        drop_next   = 1'b0;
        case (state_reg)
          ST_IDLE: begin
            if (l4_i[gi]) begin
              pretrg_next = pretrigger_vector_i[gi*PRETRG_BITS +: PRETRG_BITS];
              if (delay_vector_i[gi*DELAY_BITS +: DELAY_BITS] == '0) begin
                state_next = ST_PENDING;
              end else begin
                count_next = delay_vector_i[gi*DELAY_BITS +: DELAY_BITS];
                state_next = ST_DELAY;
              end
            end
          end
          ST_DELAY: begin
            drop_next  = l4_i[gi];
            count_next = count_reg - 1'b1;
            if (count_reg == DELAY_BITS'(1)) begin
              state_next = ST_PENDING;
            end
          end
          ST_PENDING: begin
            // A pulse coinciding with the grant is dropped too: the source is busy.
            drop_next = l4_i[gi];
            if (grant_hit) begin
              state_next = ST_IDLE;
            end
          end
          default: begin
            state_next = ST_IDLE;
          end
        endcase
      end

      // Per-source state register.
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          state_reg  <= ST_IDLE;
          count_reg  <= '0;
          pretrg_reg <= '0;
          drop_reg   <= 1'b0;
        end else begin
          state_reg  <= state_next;
          count_reg  <= count_next;
          pretrg_reg <= pretrg_next;
          drop_reg   <= drop_next;
        end
      end

`ifdef L4_SCHED_DROP_COUNT_EN
      logic [15:0] drop_cnt_reg;

      assign drop_count_o[gi*16 +: 16] = drop_cnt_reg;

      // Saturating drop counter; clear wins over a same-cycle increment.
      always_ff @(posedge clk_i) begin
        if (rst_i || drop_count_clr_i) begin
          drop_cnt_reg <= '0;
        end else if (drop_reg && (drop_cnt_reg != 16'hFFFF)) begin
          drop_cnt_reg <= drop_cnt_reg + 16'd1;
        end
      end
`endif
    end
  endgenerate

endmodule

// File: tb/tb_l4_trigger_scheduler.sv
// Directed testbench for l4_trigger_scheduler. Inputs change 1 time unit after
// the rising edge; outputs are sampled at that same point, so every check sees
// the state registered by the preceding edge.
// Build with L4_SCHED_DROP_COUNT_EN defined to also exercise the drop counters.
module tb_l4_trigger_scheduler;

  localparam int NUM_L4      = 5;
  localparam int PRETRG_BITS = 4;
  localparam int DELAY_BITS  = 8;
  localparam int SRC_BITS    = 3;

  logic                          clk = 1'b0;
  logic                          rst = 1'b1;
  logic [NUM_L4-1:0]             l4 = '0;
  logic [PRETRG_BITS*NUM_L4-1:0] pre_vec = '0;
  logic [DELAY_BITS*NUM_L4-1:0]  dly_vec = '0;
  logic                          trig;
  logic [SRC_BITS-1:0]           trig_src;
  logic [PRETRG_BITS-1:0]        trig_pre;
  logic                          ack = 1'b1;
  logic [NUM_L4-1:0]             pending;
  logic [NUM_L4-1:0]             drop;
`ifdef L4_SCHED_DROP_COUNT_EN
  logic                          drop_clr = 1'b0;
  logic [NUM_L4*16-1:0]          drop_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  l4_trigger_scheduler #(
    .NUM_L4      (NUM_L4),
    .PRETRG_BITS (PRETRG_BITS),
    .DELAY_BITS  (DELAY_BITS),
    .SRC_BITS    (SRC_BITS)
  ) dut (
    .clk_i               (clk),
    .rst_i               (rst),
    .l4_i                (l4),
    .pretrigger_vector_i (pre_vec),
    .delay_vector_i      (dly_vec),
    .trig_o              (trig),
    .trig_src_o          (trig_src),
    .trig_pretrigger_o   (trig_pre),
    .trig_ack_i          (ack),
    .pending_o           (pending),
    .drop_o              (drop)
`ifdef L4_SCHED_DROP_COUNT_EN
    ,
    .drop_count_clr_i    (drop_clr),
    .drop_count_o        (drop_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int n, input logic [PRETRG_BITS-1:0] p, input logic [DELAY_BITS-1:0] d);
    pre_vec[n*PRETRG_BITS +: PRETRG_BITS] = p;
    dly_vec[n*DELAY_BITS +: DELAY_BITS]   = d;
  endtask

  // Drive a one-cycle pulse; returns one edge after it was sampled.
  task automatic pulse(input logic [NUM_L4-1:0] mask);
    l4 = mask;
    tick();
    l4 = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int seen;

    tick();
    tick();
    rst = 1'b0;

    // Reset state
    check("rst_trig", 32'(trig), 32'd0);
    check("rst_src", 32'(trig_src), 32'd0);
    check("rst_pre", 32'(trig_pre), 32'd0);
    check("rst_pending", 32'(pending), 32'd0);
    check("rst_drop", 32'(drop), 32'd0);

    // rf0, delay 0: trig_o two edges after the drive edge, then clears
    set_src(0, 4'd5, 8'd0);
    ack = 1'b1;
    pulse(5'b00001);
    check("t1_pending", 32'(pending), 32'h01);
    check("t1_trig_early", 32'(trig), 32'd0);
    tick();
    check("t1_trig", 32'(trig), 32'd1);
    check("t1_src", 32'(trig_src), 32'd0);
    check("t1_pre", 32'(trig_pre), 32'd5);
    check("t1_pending_fall", 32'(pending), 32'h00);
    tick();
    check("t1_trig_clear", 32'(trig), 32'd0);

    // cal, delay 20, with a second pulse dropped mid-delay
    set_src(3, 4'd7, 8'd20);
    pulse(5'b01000);                 // now at t+1
    check("t2_pending_dly", 32'(pending), 32'h00);
    repeat (4) tick();               // t+5
    l4 = 5'b01000;
    tick();                          // t+6
    l4 = '0;
    check("t2_drop", 32'(drop), 32'h08);
    tick();                          // t+7
    check("t2_drop_clear", 32'(drop), 32'h00);
    repeat (13) tick();              // t+20
    check("t2_pending_early", 32'(pending), 32'h00);
    tick();                          // t+21
    check("t2_pending", 32'(pending), 32'h08);
    check("t2_trig_early", 32'(trig), 32'd0);
    tick();                          // t+22
    check("t2_trig", 32'(trig), 32'd1);
    check("t2_src", 32'(trig_src), 32'd3);
    check("t2_pre", 32'(trig_pre), 32'd7);
    seen = 0;
    repeat (30) begin
      tick();
      if (trig) seen++;
    end
    check("t2_no_extra", 32'(seen), 32'd0);

    // All five sources at once, consumer stalled for 4 cycles
    do_reset();
    for (int n = 0; n < NUM_L4; n++) set_src(n, 4'(n + 9), 8'd0);
    ack = 1'b0;
    pulse(5'b11111);
    check("t3_pending_all", 32'(pending), 32'h1f);
    check("t3_trig_early", 32'(trig), 32'd0);
    tick();
    check("t3_src0", 32'(trig_src), 32'd0);
    check("t3_pre0", 32'(trig_pre), 32'd9);
    check("t3_pending_rest", 32'(pending), 32'h1e);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("t3_hold_trig", 32'(trig), 32'd1);
      check("t3_hold_src", 32'(trig_src), 32'd0);
    end
    ack = 1'b1;
    for (int s = 1; s < NUM_L4; s++) begin
      tick();
      check("t3_trig", 32'(trig), 32'd1);
      check("t3_src", 32'(trig_src), 32'(s));
      check("t3_pre", 32'(trig_pre), 32'(s + 9));
    end

    // After the src 4 grant, src 2 and src 0 together: wrap makes src 0 first
    l4 = 5'b00101;
    tick();
    l4 = '0;
    check("t4_gap", 32'(trig), 32'd0);
    check("t4_pending", 32'(pending), 32'h05);
    tick();
    check("t4_src_first", 32'(trig_src), 32'd0);
    check("t4_pre_first", 32'(trig_pre), 32'd9);
    tick();
    check("t4_src_second", 32'(trig_src), 32'd2);
    check("t4_pre_second", 32'(trig_pre), 32'd11);
    tick();
    check("t4_trig_clear", 32'(trig), 32'd0);

    // ext in a 50-cycle delay, reset 10 cycles after the pulse
    set_src(4, 4'd3, 8'd50);
    pulse(5'b10000);
    check("t5_pending_dly", 32'(pending), 32'h00);
    repeat (9) tick();
    rst = 1'b1;
    tick();
    check("t5_rst_trig", 32'(trig), 32'd0);
    check("t5_rst_src", 32'(trig_src), 32'd0);
    check("t5_rst_pre", 32'(trig_pre), 32'd0);
    check("t5_rst_pending", 32'(pending), 32'h00);
    rst = 1'b0;
    seen = 0;
    repeat (60) begin
      tick();
      if (trig || (pending != '0)) seen++;
    end
    check("t5_lost", 32'(seen), 32'd0);

    // rf1, maximum delay 255
    set_src(1, 4'd6, 8'd255);
    pulse(5'b00010);
    repeat (254) tick();             // t+255
    check("t6_pending_early", 32'(pending), 32'h00);
    tick();                          // t+256
    check("t6_pending", 32'(pending), 32'h02);
    tick();
    check("t6_src", 32'(trig_src), 32'd1);
    check("t6_pre", 32'(trig_pre), 32'd6);
    tick();
    check("t6_trig_clear", 32'(trig), 32'd0);

`ifdef L4_SCHED_DROP_COUNT_EN
    // cpu held in delay; three dropped pulses, then a fourth with clear
    set_src(2, 4'd1, 8'd100);
    pulse(5'b00100);
    for (int k = 0; k < 3; k++) begin
      pulse(5'b00100);
      tick();
    end
    check("t7_count3", 32'(drop_count[2*16 +: 16]), 32'd3);
    pulse(5'b00100);
    check("t7_drop4", 32'(drop), 32'h04);
    drop_clr = 1'b1;
    tick();
    drop_clr = 1'b0;
    check("t7_count_clr", 32'(drop_count[2*16 +: 16]), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/l4_trigger_scheduler.md
# l4_trigger_scheduler

Sequences the five L4 trigger sources (rf0, rf1, cpu, cal, ext) into a single readout trigger stream. Each source pulse is held for that source's programmed delay, then queued. Pending sources are granted round-robin onto one valid/ack output carrying the source index and the source's pretrigger depth. The block sits between the L4 trigger logic (plus the packed per-source pretrigger/delay vectors) and the readout/digitizer request logic.

## Interface
Parameters:
- `NUM_L4`, default 5: number of L4 sources; bit order is rf0=0, rf1=1, cpu=2, cal=3, ext=4.
- `PRETRG_BITS`, default 4: pretrigger field width per source.
- `DELAY_BITS`, default 8: delay field width per source.
- `SRC_BITS`, default 3: width of the source index, ≥ clog2(`NUM_L4`).

Ports:
- `clk_i` in 1: the block's single clock.
- `rst_i` in 1: reset, synchronous and active-high.
- `l4_i` in `NUM_L4`: single-cycle trigger pulses, one bit per source.
- `pretrigger_vector_i` in `PRETRG_BITS*NUM_L4`: packed pretrigger values; source n occupies bits [n*PRETRG_BITS +: PRETRG_BITS].
- `delay_vector_i` in `DELAY_BITS*NUM_L4`: packed delay values, same packing.
- `trig_o` out 1: an output trigger is valid.
- `trig_src_o` out `SRC_BITS`: index of the granted source.
- `trig_pretrigger_o` out `PRETRG_BITS`: pretrigger value of the granted source.
- `trig_ack_i` in 1: consumer accepts the trigger in the current cycle.
- `pending_o` out `NUM_L4`: per-source pending flags (status).
- `drop_o` out `NUM_L4`: one-cycle pulse when a source pulse is discarded.

## Operation
- Each source has a state machine: IDLE → DELAY → PENDING → IDLE.
- IDLE, `l4_i[n]`=1:
  - Latch delay[n] and pretrigger[n] from the vectors in that cycle.
  - If delay = 0, go to PENDING; otherwise load the counter with the delay and go to DELAY.
- DELAY: decrement the counter each cycle. When the counter equals 1, the next state is PENDING.
- PENDING: hold until granted, then return to IDLE on the grant edge.
- `l4_i[n]`=1 while source n is in DELAY or PENDING:
  - The pulse is dropped and `drop_o[n]`=1 next cycle.
  - The latched values and the counter are unchanged.
- A pulse arriving in the same cycle the source is granted (PENDING→IDLE) is also dropped.
- Output slot:
  - The slot is free when `trig_o`=0, or when `trig_o`=1 and `trig_ack_i`=1.
  - When the slot is free and any source is PENDING, grant one source round-robin.
  - Search order is last_grant+1, +2, … with wrap modulo `NUM_L4`.
  - On grant, register `trig_o`=1, `trig_src_o`, and `trig_pretrigger_o` (the latched value), and update last_grant.
- Slot free and nothing pending: `trig_o` clears to 0.
- `trig_o`=1 and `trig_ack_i`=0: all outputs hold stable.
- `trig_ack_i` while `trig_o`=0 is ignored.
- Delay values changing while a source is in DELAY have no effect on that source.

## Timing
- Reset values:
  - `trig_o`=0, `trig_src_o`=0, `trig_pretrigger_o`=0.
  - `pending_o`=0, `drop_o`=0.
  - All sources IDLE, counters 0.
  - last_grant=`NUM_L4`-1, so source 0 has first priority after reset.
- Pulse sampled at edge t with delay D:
  - `pending_o[n]` rises at edge t+1+D.
  - `trig_o` rises at edge t+2+D if the slot is free and no other source wins.
- Minimum pulse-to-`trig_o` latency is 2 cycles (D=0).
- Maximum delay is 2^DELAY_BITS−1 cycles, with no wrap.
- Back-to-back throughput is one trigger per cycle while the consumer holds `trig_ack_i`=1.
- `pending_o[n]` falls on the edge its grant is registered.
- A `rst_i` edge mid-DELAY or mid-handshake returns everything to reset values; in-flight triggers are lost.

## Configuration
- `L4_SCHED_DROP_COUNT_EN` defined:
  - Adds output `drop_count_o`, `NUM_L4`*16 bits: per-source counters using the same packing as the input vectors.
  - Each counter increments on its `drop_o` pulse and saturates at 16'hFFFF.
  - Counters are cleared by `rst_i` and by input `drop_count_clr_i` (1 bit, synchronous).
  - `drop_count_clr_i` has priority over an increment in the same cycle.
- Undefined: neither port exists and no counter logic is built; `drop_o` behaviour is unchanged.

## Test plan
- rf0 delay=0, pretrigger=5, `trig_ack_i` tied 1, pulse at edge 10 → `trig_o`=1 at edge 12 with src=0 and pretrigger=5, then `trig_o`=0 at edge 13.
- cal delay=20, pulse at edge 10 → `pending_o[3]` rises at edge 31 and `trig_o` with src=3 at edge 32; a second cal pulse at edge 15 produces `drop_o[3]` at edge 16 and no extra trigger.
- All five sources delay=0, pulsed together, `trig_ack_i` held 0 for 4 cycles then 1 → first grant is src 0, held stable for 4 cycles; remaining grants follow 1, 2, 3, 4 on consecutive cycles.
- After the src 4 grant, pulse src 2 and src 0 together (delay=0) → src 0 granted first (wrap from last_grant=4), then src 2.
- ext in DELAY (delay=50) and `rst_i` asserted at pulse+10 → all outputs at reset values next edge; no trigger ever issued for that pulse.
- With `L4_SCHED_DROP_COUNT_EN`: 3 dropped cpu pulses → `drop_count_o[2*16 +: 16]`=3; `drop_count_clr_i` coinciding with a 4th drop → count=0.
